// File: rtl/traffic_pkg.sv
`timescale 1ns/1ps
// Shared types and helpers for the mesh traffic source: destination modes,
// controller states, LFSR constants and packet field offsets.
package traffic_pkg;

    typedef enum logic [1:0] {
        FIXED   = 2'd0,
        RANDOM  = 2'd1,
        REVERSE = 2'd2
    } mode_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_e;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    // Right-shifting Galois form of x^16+x^14+x^13+x^11+1.
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return (s >> 1) ^ (s[0] ? LFSR_TAPS : 16'h0000);
    endfunction

    function automatic int valid_bit(input int fifo_w);
        return fifo_w - 1;
    endfunction

    function automatic int dest_lsb(input int fifo_w, input int addr_w);
        return fifo_w - 1 - addr_w;
    endfunction

    function automatic int src_lsb(input int fifo_w, input int addr_w);
        return fifo_w - 1 - 2 * addr_w;
    endfunction

    function automatic int ts_width(input int fifo_w, input int addr_w);
        return fifo_w - 1 - 2 * addr_w;
    endfunction

endpackage

// File: rtl/src_fifo.sv
`timescale 1ns/1ps
// Small synchronous source queue. Read data comes straight from the storage
// flops at the read pointer, so a pushed entry is visible one cycle later.
module src_fifo #(
    parameter int DEPTH = 4,
    parameter int DW    = 27
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic [DW-1:0] wdata,
    input  logic          pop,
    output logic [DW-1:0] rdata,
    output logic          full,
    output logic          empty
);

    localparam int PW = $clog2(DEPTH);

    logic [DEPTH-1:0][DW-1:0] mem_q, mem_d;
    logic [PW-1:0]            wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]            rd_ptr_q, rd_ptr_d;
    logic [PW:0]              cnt_q, cnt_d;
    logic                     do_push, do_pop;

    assign full    = (cnt_q == (PW+1)'(DEPTH));
    assign empty   = (cnt_q == '0);
    assign rdata   = mem_q[rd_ptr_q];
    // Full refuses a push even when a pop frees a slot in the same cycle.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = wdata;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: rtl/traffic_source.sv
`timescale 1ns/1ps
// Per-node packet generator for a mesh/torus: LFSR-paced injection into a
// small queue, a held output register toward the network, and run statistics.
module traffic_source
    import traffic_pkg::*;
#(
    parameter int   X_NODES    = 3,
    parameter int   Y_NODES    = 3,
    parameter int   FIFO_WIDTH = 32,
    parameter int   NODE_ID    = 0,
    parameter int   MODE       = 0,
    parameter int   SRC_DEPTH  = 4,
    localparam int  N          = X_NODES * Y_NODES,
    localparam int  ADDR_W     = $clog2(N)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic [7:0]            rateThreshold,
    input  logic [15:0]           packetLimit,
    input  logic [ADDR_W-1:0]     fixedDest,
    output logic [FIFO_WIDTH-1:0] nodeToNetworkData,
    output logic                  nodeToNetworkWriteRequest,
    input  logic                  networkToNodeHoldRequest,
    output logic [15:0]           packetsSent,
    output logic [15:0]           droppedCount,
    output logic [15:0]           stallCycles,
    output logic                  done
);

    localparam int TS_W  = ts_width(FIFO_WIDTH, ADDR_W);
    localparam int QW    = ADDR_W + TS_W;
    localparam int VLD_B = valid_bit(FIFO_WIDTH);
    localparam int DST_L = dest_lsb(FIFO_WIDTH, ADDR_W);
    localparam int SRC_L = src_lsb(FIFO_WIDTH, ADDR_W);

    if (TS_W < 8) begin : g_bad_ts_w
        $error("traffic_source: timestamp field narrower than 8 bits");
    end
    if (SRC_DEPTH < 2 || (SRC_DEPTH & (SRC_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("traffic_source: SRC_DEPTH must be a power of 2, >= 2");
    end
    if (NODE_ID < 0 || NODE_ID >= N) begin : g_bad_node
        $error("traffic_source: NODE_ID out of range");
    end

    state_e                  state_q, state_d;
    logic [15:0]             lfsr_q, lfsr_d;
    logic [TS_W-1:0]         ts_q, ts_d;
    logic [15:0]             gen_q, gen_d;
    logic [FIFO_WIDTH-1:0]   data_q, data_d;
    logic                    wr_q, wr_d;
    logic [15:0]             sent_q, sent_d;
    logic [15:0]             drop_q, drop_d;
    logic [15:0]             stall_q, stall_d;
    logic                    done_q, done_d;

    logic                    under_limit, gen_ev, xfer, load;
    logic                    q_full, q_empty;
    logic [QW-1:0]           q_rdata;
    logic [ADDR_W-1:0]       dest;
    int                      rnd;

    assign under_limit = (packetLimit == 16'd0) || (gen_q < packetLimit);
    assign gen_ev      = (state_q == RUN) && enable && under_limit &&
                         (lfsr_q[15:8] < rateThreshold);
    assign xfer        = wr_q && !networkToNodeHoldRequest;
    assign load        = !q_empty && (!wr_q || xfer);

    // Random mode folds the LFSR draw into 0..N-1 and steps past our own id.
    always_comb begin
        rnd = int'(lfsr_q[ADDR_W-1:0]);
        if (rnd >= N) rnd = rnd - N;
        if (rnd == NODE_ID) rnd = (rnd + 1) % N;
        case (MODE)
            int'(RANDOM):  dest = ADDR_W'(rnd);
            int'(REVERSE): dest = ADDR_W'(N - 1 - NODE_ID);
            default:       dest = fixedDest;
        endcase
    end

    src_fifo #(
        .DEPTH (SRC_DEPTH),
        .DW    (QW)
    ) u_src_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (gen_ev),
        .wdata ({dest, ts_q}),
        .pop   (load),
        .rdata (q_rdata),
        .full  (q_full),
        .empty (q_empty)
    );

    always_comb begin
        state_d = state_q;
        lfsr_d  = (state_q == IDLE) ? lfsr_q : lfsr_step(lfsr_q);
        ts_d    = ts_q + 1'b1;
        gen_d   = gen_q;
        data_d  = data_q;
        wr_d    = wr_q;
        sent_d  = sent_q;
        drop_d  = drop_q;
        stall_d = stall_q;

        if (gen_ev) gen_d = gen_q + 16'd1;
        if (gen_ev && q_full && drop_q != 16'hFFFF) drop_d = drop_q + 16'd1;
        if (xfer && sent_q != 16'hFFFF) sent_d = sent_q + 16'd1;
        if (wr_q && networkToNodeHoldRequest && stall_q != 16'hFFFF) stall_d = stall_q + 16'd1;

        if (load) begin
            data_d[VLD_B]             = 1'b1;
            data_d[DST_L +: ADDR_W]   = q_rdata[TS_W +: ADDR_W];
            data_d[SRC_L +: ADDR_W]   = ADDR_W'(NODE_ID);
            data_d[TS_W-1:0]          = q_rdata[TS_W-1:0];
            wr_d                      = 1'b1;
        end else if (xfer) begin
            wr_d = 1'b0;
        end

        case (state_q)
            IDLE: if (enable) begin
                state_d = RUN;
                ts_d    = '0;
                gen_d   = '0;
                sent_d  = '0;
                drop_d  = '0;
                stall_d = '0;
            end
            RUN: if (!enable || (packetLimit != 16'd0 && gen_q >= packetLimit)) state_d = DRAIN;
            DRAIN: if (q_empty && !wr_q) state_d = DONE;
            DONE: if (!enable) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            lfsr_q  <= LFSR_SEED ^ 16'(NODE_ID);
            ts_q    <= '0;
            gen_q   <= '0;
            data_q  <= '0;
            wr_q    <= 1'b0;
            sent_q  <= '0;
            drop_q  <= '0;
            stall_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            lfsr_q  <= lfsr_d;
            ts_q    <= ts_d;
            gen_q   <= gen_d;
            data_q  <= data_d;
            wr_q    <= wr_d;
            sent_q  <= sent_d;
            drop_q  <= drop_d;
            stall_q <= stall_d;
            done_q  <= done_d;
        end
    end

    assign nodeToNetworkData         = data_q;
    assign nodeToNetworkWriteRequest = wr_q;
    assign packetsSent               = sent_q;
    assign droppedCount              = drop_q;
    assign stallCycles               = stall_q;
    assign done                      = done_q;

endmodule

// File: doc/traffic_source.md
TRAFFIC_SOURCE -- requirements
Module: traffic_source

Interface
REQ-001 X_NODES, 3, mesh/tori columns; Y_NODES, 3, rows; N = X_NODES*Y_NODES.
REQ-002 FIFO_WIDTH, 32, packet width; ADDR_W = $clog2(N); TS_W = FIFO_WIDTH-1-2*ADDR_W (>=8, elaboration error otherwise).
REQ-003 NODE_ID, 0, this node's index (0..N-1); MODE, 0, destination mode (0 fixed, 1 uniform random, 2 reverse); SRC_DEPTH, 4, source queue depth (power of 2, >=2).
REQ-004 clk  in  1  single clock, all state on rising edge.
REQ-005 reset  in  1  asynchronous, active-low reset.
REQ-006 enable  in  1  run request; rateThreshold  in  8  injection probability x256; packetLimit  in  16  packets to generate (0 = unlimited); fixedDest  in  ADDR_W  MODE 0 destination.
REQ-007 nodeToNetworkData  out  FIFO_WIDTH  packet; nodeToNetworkWriteRequest  out  1  packet valid; networkToNodeHoldRequest  in  1  network back-pressure.
REQ-008 packetsSent  out  16; droppedCount  out  16; stallCycles  out  16; done  out  1.

Function
REQ-009 Packet format: [W-1]=1 valid, next ADDR_W bits destination, next ADDR_W bits NODE_ID, low TS_W bits timestamp.
REQ-010 Free-running TS_W-bit cycle counter, cleared on entry to RUN, wraps; timestamp = counter value in generation cycle.
REQ-011 16-bit Galois LFSR, poly x^16+x^14+x^13+x^11+1, seed 16'hACE1 ^ NODE_ID, advances every cycle outside IDLE.
REQ-012 Generation event in RUN: lfsr[15:8] < rateThreshold and (packetLimit==0 or generated < packetLimit); threshold 0 = never.
REQ-013 Destination: MODE 0 fixedDest; MODE 2 N-1-NODE_ID; MODE 1 r=lfsr[ADDR_W-1:0], r>=N -> r-N, then r==NODE_ID -> (r+1) mod N.
REQ-014 Event pushes {dest, timestamp} into queue; queue full -> packet dropped, droppedCount +1 (saturating); full blocks push even if popping same cycle; generated count advances on push or drop.
REQ-015 Output register loads from non-empty queue when writeRequest=0 or transfer occurs this cycle; event in cycle t -> writeRequest earliest in cycle t+2.
REQ-016 Transfer = writeRequest=1 and hold=0 at rising edge; packetsSent +1 (saturating).
REQ-017 writeRequest=1 and hold=1: data and writeRequest held stable; stallCycles +1 (saturating).
REQ-018 FSM IDLE->RUN on enable=1 (clears counters, generated count, timestamp); RUN->DRAIN on enable=0 or limit reached; DRAIN->DONE when queue empty and writeRequest=0; DONE->IDLE on enable=0.
REQ-019 done=1 only in DONE; no generation in DRAIN/DONE/IDLE; queued packets always drained, never discarded except by reset.

Reset
REQ-020 reset low (any time, incl. mid-transfer): FSM IDLE, queue empty, data 0, writeRequest 0, done 0, all counters 0, LFSR reseeded.
REQ-021 First generation no earlier than second rising edge after reset release with enable=1.

Structure
REQ-022 Shared package traffic_pkg: mode enum (FIXED, RANDOM, REVERSE), FSM state enum, LFSR seed/taps constants, field-offset functions of FIFO_WIDTH/ADDR_W.
REQ-023 One sub-module src_fifo (synchronous FIFO, SRC_DEPTH x (ADDR_W+TS_W), full/empty flags, registered read); rest in traffic_source.

Verification (X=Y=3, W=32, NODE_ID=8, SRC_DEPTH=4)
REQ-024 Reset asserted mid-stream -> next cycle writeRequest=0, data=0, packetsSent=0, done=0.
REQ-025 MODE 0, fixedDest=4, rate=255, limit=3, hold=0 -> exactly 3 transfers, data[31]=1, [30:27]=4, [26:23]=8, packetsSent=3, done=1.
REQ-026 Pending packet, hold high 10 cycles -> data/writeRequest stable, stallCycles=10, transfer on hold release, no loss.
REQ-027 hold high, rate=255, limit=0 -> 1 packet in output register + 4 queued, droppedCount +1 per further event, no push when full.
REQ-028 MODE 1, rate=128, limit=1000 -> every destination in 0..7, never 8, packetsSent+droppedCount=1000 at done.
REQ-029 enable dropped during RUN with 3 queued -> no new generation, 3 remaining transfers, DONE, IDLE after enable low.
